// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and coordinate helpers used by the sync
// generator, the pixel generator and the game logic.
package vga_timing_pkg;

  localparam int COORD_W     = 10;
  localparam int COORD_RANGE = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic int axis_total(input int visible, input int fp,
                                    input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  // Half-open window test [lo, hi) on an unsigned coordinate.
  function automatic logic in_window(input coord_t pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) < hi);
  endfunction

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_TOTAL   = axis_total(VGA_H_VISIBLE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_TOTAL   = axis_total(VGA_V_VISIBLE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

  localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

endpackage

// File: rtl/vga_sync_generator_if.sv
// Raster timing bundle from the sync generator to its consumers.
interface vga_sync_generator_if;
  import vga_timing_pkg::*;

  coord_t x;
  coord_t y;
  logic   visible;
  logic   hsync;
  logic   vsync;
  logic   pixel_tick;
  logic   frame_tick;

  modport master (
    output x, y, visible, hsync, vsync, pixel_tick, frame_tick
  );

  modport slave (
    input x, y, visible, hsync, vsync, pixel_tick, frame_tick
  );

endinterface

// File: rtl/vga_axis_timer.sv
// One raster axis: position counter stepped by an enable, plus registered
// active-region and sync decodes that always describe the current count.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int   VISIBLE     = VGA_H_VISIBLE,
  parameter int   FP          = VGA_H_FP,
  parameter int   SYNC        = VGA_H_SYNC,
  parameter int   BP          = VGA_H_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   step,
  output coord_t count,
  output logic   wrap,
  output logic   active,
  output logic   sync
);

  localparam int     TOTAL      = axis_total(VISIBLE, FP, SYNC, BP);
  localparam int     SYNC_START = VISIBLE + FP;
  localparam int     SYNC_END   = SYNC_START + SYNC;
  localparam coord_t LAST       = coord_t'(TOTAL - 1);

  logic   last;
  coord_t next_count;

  assign last       = (count == LAST);
  assign wrap       = step & last;
  assign next_count = last ? '0 : count + 1'b1;

  // Decodes are taken from next_count so they land on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      active <= (VISIBLE > 0);
      sync   <= ~SYNC_ACTIVE;
    end else if (step) begin
      count  <= next_count;
      active <= in_window(next_count, 0, VISIBLE);
      sync   <= in_window(next_count, SYNC_START, SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster timing source: pixel-clock divider feeding a horizontal and a
// vertical axis timer, producing aligned coordinates, blanking and syncs.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV     = 4,
  parameter int   H_VISIBLE   = VGA_H_VISIBLE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_VISIBLE   = VGA_V_VISIBLE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_sync_generator_if.master vga
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > COORD_RANGE || V_TOTAL > COORD_RANGE) begin : g_total_check
    $error("vga_sync_generator: line or frame total does not fit the coordinate width");
  end

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
    $error("vga_sync_generator: CLK_DIV must be within 1..16");
  end

  logic [DIV_W-1:0] div;
  logic             pixel_tick;
  coord_t           h_count;
  coord_t           v_count;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_active;
  logic             v_active;
  logic             h_sync;
  logic             v_sync;
  logic             blank;

  assign pixel_tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (pixel_tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Holds pixel (0,0) of the first frame after reset blanked until the first tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank <= 1'b1;
    end else if (pixel_tick) begin
      blank <= 1'b0;
    end
  end

  vga_axis_timer #(
    .VISIBLE     (H_VISIBLE),
    .FP          (H_FP),
    .SYNC        (H_SYNC),
    .BP          (H_BP),
    .SYNC_ACTIVE (SYNC_ACTIVE)
  ) u_h_timer (
    .clk    (clk),
    .rst    (rst),
    .step   (pixel_tick),
    .count  (h_count),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  vga_axis_timer #(
    .VISIBLE     (V_VISIBLE),
    .FP          (V_FP),
    .SYNC        (V_SYNC),
    .BP          (V_BP),
    .SYNC_ACTIVE (SYNC_ACTIVE)
  ) u_v_timer (
    .clk    (clk),
    .rst    (rst),
    .step   (h_wrap),
    .count  (v_count),
    .wrap   (v_wrap),
    .active (v_active),
    .sync   (v_sync)
  );

  assign vga.x          = h_count;
  assign vga.y          = v_count;
  assign vga.visible    = h_active & v_active & ~blank;
  assign vga.hsync      = h_sync;
  assign vga.vsync      = v_sync;
  assign vga.pixel_tick = pixel_tick;
  assign vga.frame_tick = v_wrap;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Scoreboard bench: default 640x480 at CLK_DIV=4 and 2, plus a reduced
// 16x9 raster at CLK_DIV=1 so whole frames fit in a short run.
module tb_vga_sync_generator;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_bc;

  always #5 clk = ~clk;

  vga_sync_generator_if ia ();
  vga_sync_generator_if ib ();
  vga_sync_generator_if ic ();

  vga_sync_generator #(.CLK_DIV(4)) dut_a (.clk(clk), .rst(rst_a), .vga(ia));

  vga_sync_generator #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_b (.clk(clk), .rst(rst_bc), .vga(ib));

  vga_sync_generator #(.CLK_DIV(2)) dut_c (.clk(clk), .rst(rst_bc), .vga(ic));

  typedef struct {
    int          idx;
    logic [31:0] v;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] pk(input int x, input int y, input logic v,
                                     input logic h, input logic s);
    logic [31:0] r;
    r = {9'd0, x[9:0], y[9:0], v, h, s};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic add_a(input int k, input int x, input int y, input logic v,
                       input logic h, input logic s);
    qa.push_back('{k, pk(x, y, v, h, s)});
  endtask

  task automatic add_b(input int k, input int x, input int y, input logic v,
                       input logic h, input logic s);
    qb.push_back('{k, pk(x, y, v, h, s)});
  endtask

  // Monitor A: compares outputs after each pixel tick against queued vectors.
  int   ticks_a = 0, hs_low_a = 0, vis_a = 0, consec_a = 0;
  int   line_t0 = -1, line_t1 = -1;
  logic prev_tick_a = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_a) begin
      ticks_a     = 0;
      prev_tick_a = 1'b0;
    end else begin
      if (prev_tick_a) begin
        ticks_a++;
        if (qa.size() > 0 && qa[0].idx == ticks_a) begin
          e = qa.pop_front();
          check($sformatf("A tick %0d", e.idx),
                pk(ia.x, ia.y, ia.visible, ia.hsync, ia.vsync), e.v);
        end
        if (line_t0 < 0 && ticks_a < 800) begin
          if (!ia.hsync) hs_low_a++;
          if (ia.visible) vis_a++;
        end
        if (ticks_a == 800 && line_t0 < 0) line_t0 = cyc;
        if (ticks_a == 1600 && line_t1 < 0) line_t1 = cyc;
        if (ia.pixel_tick) consec_a++;
      end
      prev_tick_a = ia.pixel_tick;
    end
  end

  // Monitor B: reduced raster, full frames.
  int   ticks_b = 0, vis_b = 0, vslow_b = 0, notick_b = 0, nfr_b = 0, frame_wide_b = 0;
  int   fr_t0 = -1, fr_t1 = -1;
  logic prev_tick_b = 1'b0, prev_frame_b = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_bc) begin
      ticks_b      = 0;
      prev_tick_b  = 1'b0;
      prev_frame_b = 1'b0;
    end else begin
      if (prev_tick_b) begin
        ticks_b++;
        if (qb.size() > 0 && qb[0].idx == ticks_b) begin
          e = qb.pop_front();
          check($sformatf("B tick %0d", e.idx),
                pk(ib.x, ib.y, ib.visible, ib.hsync, ib.vsync), e.v);
        end
        if (ticks_b >= 144 && ticks_b < 288) begin
          if (ib.visible) vis_b++;
          if (!ib.vsync) vslow_b++;
        end
      end
      if (!ib.pixel_tick) notick_b++;
      if (ib.frame_tick) begin
        check($sformatf("B frame_tick position %0d", nfr_b),
              pk(ib.x, ib.y, 1'b0, 1'b0, 1'b0), pk(15, 8, 1'b0, 1'b0, 1'b0));
        if (nfr_b == 0) fr_t0 = cyc;
        else if (nfr_b == 1) fr_t1 = cyc;
        nfr_b++;
        if (prev_frame_b) frame_wide_b++;
      end
      prev_frame_b = ib.frame_tick;
      prev_tick_b  = ib.pixel_tick;
    end
  end

  // Monitor C: line period and inter-tick stability.
  int          unstable_c = 0, nwrap_c = 0, wrap_t0 = -1, wrap_t1 = -1;
  logic        prev_tick_c = 1'b0, have_c = 1'b0;
  logic [31:0] prev_snap_c = '0;
  logic [31:0] snap_c;
  logic [9:0]  prev_x_c = '0;

  always @(negedge clk) begin
    if (rst_bc) begin
      prev_tick_c = 1'b0;
      have_c      = 1'b0;
    end else begin
      snap_c = pk(ic.x, ic.y, ic.visible, ic.hsync, ic.vsync);
      if (have_c && !prev_tick_c && snap_c != prev_snap_c) unstable_c++;
      if (have_c && prev_x_c == 10'd799 && ic.x == 10'd0) begin
        if (nwrap_c == 0) wrap_t0 = cyc;
        else if (nwrap_c == 1) wrap_t1 = cyc;
        nwrap_c++;
      end
      prev_snap_c = snap_c;
      prev_x_c    = ic.x;
      prev_tick_c = ic.pixel_tick;
      have_c      = 1'b1;
    end
  end

  initial begin
    logic [11:0] mask;
    int          n;
    int          first;

    rst_a  = 1'b1;
    rst_bc = 1'b1;

    add_a(1, 1, 0, 1, 1, 1);     add_a(639, 639, 0, 1, 1, 1);
    add_a(640, 640, 0, 0, 1, 1); add_a(655, 655, 0, 0, 1, 1);
    add_a(656, 656, 0, 0, 0, 1); add_a(751, 751, 0, 0, 0, 1);
    add_a(752, 752, 0, 0, 1, 1); add_a(799, 799, 0, 0, 1, 1);
    add_a(800, 0, 1, 1, 1, 1);   add_a(801, 1, 1, 1, 1, 1);

    add_b(1, 1, 0, 1, 1, 1);     add_b(7, 7, 0, 1, 1, 1);
    add_b(8, 8, 0, 0, 1, 1);     add_b(10, 10, 0, 0, 0, 1);
    add_b(12, 12, 0, 0, 0, 1);   add_b(13, 13, 0, 0, 1, 1);
    add_b(16, 0, 1, 1, 1, 1);    add_b(79, 15, 4, 0, 1, 1);
    add_b(80, 0, 5, 0, 1, 0);    add_b(111, 15, 6, 0, 1, 0);
    add_b(112, 0, 7, 0, 1, 1);   add_b(143, 15, 8, 0, 1, 1);
    add_b(144, 0, 0, 1, 1, 1);   add_b(145, 1, 0, 1, 1, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("A reset position/levels", pk(ia.x, ia.y, ia.visible, ia.hsync, ia.vsync),
          pk(0, 0, 1'b0, 1'b1, 1'b1));
    check("A reset pixel_tick", ia.pixel_tick, 0);
    check("A reset frame_tick", ia.frame_tick, 0);
    check("B reset position/levels", pk(ib.x, ib.y, ib.visible, ib.hsync, ib.vsync),
          pk(0, 0, 1'b0, 1'b1, 1'b1));

    @(posedge clk);
    #1;
    rst_a  = 1'b0;
    rst_bc = 1'b0;

    mask = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ia.pixel_tick) mask[k-1] = 1'b1;
    end
    check("A divider tick cycles", {20'd0, mask}, {20'd0, 12'b1000_1000_1000});

    n = 0;
    while (!(line_t1 >= 0 && ia.x == 10'd300) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("A position before mid-line reset", pk(ia.x, ia.y, 1'b0, 1'b0, 1'b0),
          pk(300, 2, 1'b0, 1'b0, 1'b0));

    @(posedge clk);
    #1;
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    check("A after mid-line reset", pk(ia.x, ia.y, ia.visible, ia.hsync, ia.vsync),
          pk(0, 0, 1'b0, 1'b1, 1'b1));
    check("A pixel_tick after mid-line reset", ia.pixel_tick, 0);

    add_a(1, 1, 0, 1, 1, 1);
    add_a(2, 2, 0, 1, 1, 1);

    first = -1;
    for (int k = 1; k <= 20 && first < 0; k++) begin
      @(negedge clk);
      if (ia.pixel_tick) first = k;
    end
    check("A first tick after mid-line reset", first, 4);

    repeat (10) @(negedge clk);

    check("A vectors outstanding", qa.size(), 0);
    check("A hsync low ticks in line 0", hs_low_a, 96);
    check("A visible ticks in line 0", vis_a, 639);
    check("A line period clks", line_t1 - line_t0, 3200);
    check("A consecutive pixel_ticks", consec_a, 0);

    check("B vectors outstanding", qb.size(), 0);
    check("B frame period clks", fr_t1 - fr_t0, 144);
    check("B frame_tick wider than one clk", frame_wide_b, 0);
    check("B visible ticks in frame 2", vis_b, 32);
    check("B vsync low ticks in frame 2", vslow_b, 32);
    check("B cycles without pixel_tick", notick_b, 0);

    check("C line period clks", wrap_t1 - wrap_t0, 1600);
    check("C output changes between ticks", unstable_c, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
